// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared out-of-order core types and widths
package ooo_pkg;

  localparam int INST_ID_W    = 6;
  localparam int FU_COUNT_DEF = 4;

  typedef logic [INST_ID_W-1:0] inst_id_t;

  // Width of an FU index; never below one bit so single-FU builds still have a port
  function automatic int fuc_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FUC_BITS = fuc_bits(FU_COUNT_DEF);

endpackage

// File: rtl/completion_fifo.sv
// rtl/completion_fifo.sv - per-FU completion FIFO with push/pop/full/empty/count
module completion_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_pop_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_head];

  // A full FIFO still accepts a push when its head leaves in the same cycle
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + PW'(1);
      if (w_do_pop)  r_head <= r_head + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; when full, tail equals head and the old head is read before it is overwritten
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_tail] <= i_push_data;
  end

endmodule

// File: rtl/fu_completion_arbiter.sv
// rtl/fu_completion_arbiter.sv - round-robin merge of FU completions onto the ROB port; FU_COMPLETION_PERF_EN adds per-FU counters
module fu_completion_arbiter
  import ooo_pkg::*;
#(
  parameter int INST_ID_BITS = INST_ID_W,
  parameter int FU_COUNT     = FU_COUNT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [FU_COUNT-1:0]                    fu_out_valid,
  input  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]  fu_out_inst_id,
  output logic [FU_COUNT-1:0]                    fu_stall,
  output logic                                   rob_complete_valid,
  output logic [INST_ID_BITS-1:0]                rob_complete_inst_id,
  output logic [fuc_bits(FU_COUNT)-1:0]          rob_complete_fu,
  input  logic                                   rob_complete_ready,
  output logic                                   overflow_err
`ifdef FU_COMPLETION_PERF_EN
  , output logic [FU_COUNT-1:0][31:0]            perf_complete_count
`endif
);

  localparam int FB  = fuc_bits(FU_COUNT);
  localparam int FB1 = FB + 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FB:0] FU_N = FB1'(FU_COUNT);

  logic [FU_COUNT-1:0]     w_empty;
  logic [FU_COUNT-1:0]     w_full;
  logic [FU_COUNT-1:0]     w_pop;
  logic [FU_COUNT-1:0]     w_drop;
  logic [FU_COUNT-1:0]     w_rot;
  logic [INST_ID_BITS-1:0] w_head [FU_COUNT];
  logic [CW-1:0]           w_count [FU_COUNT];
  logic                    w_load;
  logic                    w_found;
  logic [FB-1:0]           w_off;
  logic [FB-1:0]           w_grant;
  logic [FB-1:0]           w_rr_next;
  logic [FB:0]             w_sum;
  logic [FB:0]             w_inc;

  logic                    r_valid;
  logic [INST_ID_BITS-1:0] r_id;
  logic [FB-1:0]           r_fu;
  logic [FB-1:0]           r_rr;
  logic                    r_ovf;

  for (genvar g = 0; g < FU_COUNT; g++) begin : g_fu
    completion_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INST_ID_BITS)
    ) u_fifo (
      .i_clk       (clk),
      .i_rst_n     (rst),
      .i_push      (fu_out_valid[g]),
      .i_push_data (fu_out_inst_id[g]),
      .i_pop       (w_pop[g]),
      .o_pop_data  (w_head[g]),
      .o_full      (w_full[g]),
      .o_empty     (w_empty[g]),
      .o_count     (w_count[g])
    );

    // Stall one entry early so a completion already in flight still has a slot
    assign fu_stall[g] = (w_count[g] >= CW'(FIFO_DEPTH - 1));
    assign w_pop[g]    = w_load & w_found & (w_grant == FB'(g));
  end

  assign w_load = ~r_valid | rob_complete_ready;
  assign w_drop = fu_out_valid & w_full & ~w_pop;

  // Rotate occupancy so bit 0 is the FU the round-robin pointer names
  always_comb begin
    w_rot = FU_COUNT'({~w_empty, ~w_empty} >> r_rr);
  end

  // Lowest occupied slot in rotated order is the winner
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = FU_COUNT - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = FB'(k);
      end
    end
  end

  // Map the rotated offset back to an FU index and pick the pointer after it
  always_comb begin
    w_sum     = {1'b0, r_rr} + {1'b0, w_off};
    w_grant   = (w_sum >= FU_N) ? FB'(w_sum - FU_N) : FB'(w_sum);
    w_inc     = {1'b0, w_grant} + FB1'(1);
    w_rr_next = (w_inc >= FU_N) ? FB'(w_inc - FU_N) : FB'(w_inc);
  end

  // Output register, round-robin pointer and sticky drop flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_fu    <= '0;
      r_rr    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= w_found;
        if (w_found) begin
          r_id <= w_head[w_grant];
          r_fu <= w_grant;
          r_rr <= w_rr_next;
        end
      end
      if (|w_drop) r_ovf <= 1'b1;
    end
  end

  assign rob_complete_valid   = r_valid;
  assign rob_complete_inst_id = r_id;
  assign rob_complete_fu      = r_fu;
  assign overflow_err         = r_ovf;

`ifdef FU_COMPLETION_PERF_EN
  logic [FU_COUNT-1:0][31:0] r_perf;

  // Count accepted completions per source FU; wraps at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf <= '0;
    end else if (r_valid && rob_complete_ready) begin
      r_perf[r_fu] <= r_perf[r_fu] + 32'd1;
    end
  end

  assign perf_complete_count = r_perf;
`endif

endmodule

// File: doc/fu_completion_arbiter.md
# fu_completion_arbiter

Collects completion events from all functional-unit wrappers and serialises them onto the single reorder-buffer completion port. The block sits directly downstream of each FU wrapper's `fu_out_valid` / `fu_out_inst_id` outputs. It buffers each FU's completions in a private FIFO, selects among non-empty FIFOs round-robin, and presents one completion per cycle to the ROB over a valid/ready handshake. It also returns per-FU backpressure to the issue queues so that no completion is lost.

## Interface
- `INST_ID_BITS`, 6, width of the ROB instruction id
- `FU_COUNT`, 4, number of functional units feeding the block
- `FIFO_DEPTH`, 4, entries per FU FIFO; power of two, ≥2
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-low reset (asserted when 0)
- `fu_out_valid[FU_COUNT]`  input  1 each  FU i produced a completion this cycle
- `fu_out_inst_id[FU_COUNT]`  input  INST_ID_BITS each  id of that completion
- `fu_stall[FU_COUNT]`  output  1 each  FU i's issue queue must not issue
- `rob_complete_valid`  output  1  completion presented to ROB
- `rob_complete_inst_id`  output  INST_ID_BITS  completed instruction id
- `rob_complete_fu`  output  $clog2(FU_COUNT)  index of the source FU
- `rob_complete_ready`  input  1  ROB accepts this cycle
- `overflow_err`  output  1  sticky; a completion was dropped

## Operation
- Per-FU FIFO with head/tail pointers and a count of width $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Enqueue: `fu_out_valid[i]` at a rising edge writes `fu_out_inst_id[i]` at tail i.
- Enqueue into a full FIFO with no dequeue from it in the same cycle: the entry is dropped, the FIFO is unchanged, and `overflow_err` is set (cleared only by reset).
- Enqueue into a full FIFO with a simultaneous dequeue from it: accepted; count unchanged.
- `fu_stall[i]` = count[i] ≥ FIFO_DEPTH−1. This is combinational from the registered count and covers one completion already in flight.
- Output register (`rob_complete_*`) loads when it is empty, or when it is valid and `rob_complete_ready`=1.
  - On load, the arbiter grants the first non-empty FIFO at or after `rr_ptr`, scanning upward with wrap.
  - The granted FIFO dequeues its head.
  - `rr_ptr` advances to grant+1 (mod FU_COUNT).
  - If no FIFO is non-empty, `rob_complete_valid` drops to 0.
- While `rob_complete_valid`=1 and `rob_complete_ready`=0, the output id and FU are held stable and no FIFO dequeues.
- A FIFO is never read and written in the same entry incorrectly. Enqueue to an empty FIFO is not visible to the arbiter until the next cycle (no bypass).

## Timing
- Reset values: all FIFOs empty, `rr_ptr`=0, `rob_complete_valid`=0, `rob_complete_inst_id`=0, `rob_complete_fu`=0, `fu_stall`=all 0, `overflow_err`=0.
- Reset asserted mid-operation discards all buffered completions immediately (asynchronous).
- Latency: `fu_out_valid` high in cycle N → `rob_complete_valid` high in cycle N+2 when the FIFO was empty, the output register was free, and the FU was next in round-robin order.
- Throughput: one completion per cycle while `rob_complete_ready`=1.
- Fairness: with k non-empty FIFOs, each is granted at least once every k accepted completions.

## Configuration
- `FU_COMPLETION_PERF_EN` defined: adds output `perf_complete_count[FU_COUNT]`, 32 bits each.
  - Counter i increments by 1 on each ROB handshake (valid & ready) whose `rob_complete_fu`=i.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: the port and counters do not exist; all other behaviour is identical.

## Structure
- Shared package `ooo_pkg` holds the `inst_id_t` typedef and the `FUC_BITS` helper constant, used by both the FU wrappers and this block.
- One sub-module: `completion_fifo` (parameterised depth and width; push, pop, full, empty, count), instantiated FU_COUNT times.
- Arbitration and the output register live in the top module.

## Test plan
- Single completion: FU 2 pulses valid with id 0x15 at cycle 10, ready=1 → `rob_complete_valid`=1, id 0x15, fu 2 at cycle 12, for exactly one cycle.
- Round-robin: all 4 FUs pulse valid in the same cycle (ids 1, 2, 3, 4), ready=1 → outputs ids 1, 2, 3, 4 on 4 consecutive cycles, fu 0, 1, 2, 3.
- Backpressure hold: ready=0 for 5 cycles with FU 1 holding 3 entries → output is stable with its first id; `fu_stall[1]`=1 once count reaches 3.
- Overflow: FU 0 FIFO full, ready=0, FU 0 pulses valid with id 0x3F → FIFO contents unchanged, `overflow_err`=1 and stays set.
- Full plus simultaneous pop: FU 3 FIFO full, ready=1, output register loads from FU 3 in the same cycle FU 3 pushes id 0x07 → count stays 4, no error, 0x07 is eventually delivered.
- Async reset: assert `rst`=0 mid-stream with 6 entries buffered → all outputs return to reset values without waiting for a clock edge; after release, no stale ids appear.
